// File: rtl/bram_stream_reader.sv
// Burst read engine for the wide BRAM read port. It issues sequential reads under a
// credit check, absorbs the one-cycle read latency in a 3-entry FIFO and emits a valid/ready stream.
module bram_stream_reader #(
  parameter int DATA_WIDTH = 80,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  bram_r_valid,
  output logic [ADDR_WIDTH-1:0] bram_r_addr,
  input  logic [DATA_WIDTH-1:0] bram_r_data,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic [1:0]            dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   issue_cnt_q, issue_cnt_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;
  logic [DATA_WIDTH-1:0] fifo_data_q [3];
  logic [DATA_WIDTH-1:0] fifo_data_d [3];
  logic                  fifo_last_q [3];
  logic                  fifo_last_d [3];
  logic [1:0]            wr_ptr_q, wr_ptr_d;
  logic [1:0]            rd_ptr_q, rd_ptr_d;
  logic [1:0]            fifo_count_q, fifo_count_d;

  logic issue;
  logic final_issue;
  logic push;
  logic pop;

  // Stream handshake: a beat transfers on a cycle where m_valid & m_ready are both high.
  // Once m_valid rises, it and m_data/m_last hold until that transfer.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    len_d           = len_q;
    issue_cnt_d     = issue_cnt_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    fifo_count_d    = fifo_count_q;
    fifo_data_d     = fifo_data_q;
    fifo_last_d     = fifo_last_q;

    // Credit ignores a same-cycle pop, so at most three words are ever owed to the FIFO.
    issue       = (state_q == S_READ) &&
                  (({1'b0, fifo_count_q} + {2'b00, inflight_q}) < 3'd3);
    final_issue = issue && ((issue_cnt_q + CNT_ONE) == len_q);
    push        = inflight_q;
    pop         = (fifo_count_q != 2'd0) && m_ready;

    inflight_d      = issue;
    inflight_last_d = final_issue;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d      = base_addr;
          len_d       = length;
          issue_cnt_d = '0;
          state_d     = (length == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        if (issue) begin
          addr_d      = addr_q + ADDR_ONE;
          issue_cnt_d = issue_cnt_q + CNT_ONE;
          if (final_issue) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && fifo_last_q[rd_ptr_q]) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    if (push) begin
      fifo_data_d[wr_ptr_q] = bram_r_data;
      fifo_last_d[wr_ptr_q] = inflight_last_q;
      wr_ptr_d = (wr_ptr_q == 2'd2) ? 2'd0 : wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == 2'd2) ? 2'd0 : rd_ptr_q + 2'd1;
    end
    case ({push, pop})
      2'b10:   fifo_count_d = fifo_count_q + 2'd1;
      2'b01:   fifo_count_d = fifo_count_q - 2'd1;
      default: fifo_count_d = fifo_count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      len_q           <= '0;
      issue_cnt_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      fifo_count_q    <= '0;
      for (int i = 0; i < 3; i++) begin
        fifo_data_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
      end
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      len_q           <= len_d;
      issue_cnt_q     <= issue_cnt_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      fifo_count_q    <= fifo_count_d;
      fifo_data_q     <= fifo_data_d;
      fifo_last_q     <= fifo_last_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign bram_r_valid = issue;
  assign bram_r_addr  = addr_q;
  assign m_valid      = (fifo_count_q != 2'd0);
  assign m_data       = fifo_data_q[rd_ptr_q];
  assign m_last       = m_valid && fifo_last_q[rd_ptr_q];
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: BRAM model, randomized bursts and backpressure,
// scoreboard of expected addresses and beats, directed timing checks.
module tb_bram_stream_reader;
  localparam int DW = 80;
  localparam int AW = 9;
  localparam int W  = DW + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          busy, done, bram_r_valid;
  logic [AW-1:0] bram_r_addr;
  logic [DW-1:0] bram_r_data = '0;
  logic          m_valid, m_last;
  logic [DW-1:0] m_data;
  logic          m_ready = 1'b1;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  bram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .bram_r_valid(bram_r_valid), .bram_r_addr(bram_r_addr),
    .bram_r_data(bram_r_data), .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
    .m_ready(m_ready), .dbg_state(dbg_state)
  );

  // BRAM with one-cycle registered read
  logic [DW-1:0] mem [512];
  always @(posedge clk) if (bram_r_valid) bram_r_data <= mem[bram_r_addr];

  logic [W-1:0]  exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  int n_cmp = 0, n_err = 0;
  int issued = 0, accepted = 0, done_cnt = 0;
  int ready_mode = 0, rdy_cnt = 0;
  logic          stall_pend = 1'b0;
  logic [DW-1:0] held_data = '0;
  logic          held_last = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // m_ready: 0 = always high, 1 = 1,0,0,0 pattern, 2 = random
  initial forever begin
    @(posedge clk);
    #1;
    rdy_cnt++;
    case (ready_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = (rdy_cnt % 4 == 0);
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: read addresses, credit, hold-while-stalled, beats, done pulses
  always @(negedge clk) begin
    if (!rst) begin
      if (bram_r_valid) begin
        check("credit", (issued - accepted) < 3, 1'b1);
        check("rd_busy", busy, 1'b1);
        if (exp_addr_q.size() == 0) check("extra_read", 1'b1, 1'b0);
        else check("rd_addr", bram_r_addr, exp_addr_q.pop_front());
        issued++;
      end
      if (stall_pend) begin
        check("hold_valid", m_valid, 1'b1);
        check("hold_data", m_data, held_data);
        check("hold_last", m_last, held_last);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check("extra_beat", 1'b1, 1'b0);
        else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          check("beat_data", m_data, e[DW-1:0]);
          check("beat_last", m_last, e[DW]);
        end
        accepted++;
      end
      stall_pend = m_valid && !m_ready;
      held_data  = m_data;
      held_last  = m_last;
      if (done) done_cnt++;
    end else begin
      stall_pend = 1'b0;
    end
  end

  task automatic do_start(input logic [AW-1:0] b, input int n, input bit model);
    logic [AW-1:0] a;
    start = 1'b1;
    base_addr = b;
    length = n[AW:0];
    if (model) begin
      for (int i = 0; i < n; i++) begin
        a = b + AW'(i);
        exp_addr_q.push_back(a);
        exp_q.push_back({(i == n - 1), mem[a]});
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_reached", ok, 1'b1);
    check("sb_beats_left", exp_q.size(), 0);
    check("sb_reads_left", exp_addr_q.size(), 0);
  endtask

  task automatic run_burst(input logic [AW-1:0] b, input int n, input int mode);
    int d0;
    ready_mode = mode;
    d0 = done_cnt;
    do_start(b, n, 1'b1);
    wait_idle();
    check("done_once", done_cnt - d0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, a0;
    for (int i = 0; i < 512; i++) mem[i] = {$urandom, $urandom, $urandom};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rvalid", bram_r_valid, 1'b0);
    check("rst_raddr", bram_r_addr, '0);
    check("rst_mvalid", m_valid, 1'b0);
    check("rst_mlast", m_last, 1'b0);
    check("rst_mdata", m_data, '0);

    // Basic burst timeline relative to the start cycle T
    ready_mode = 0;
    d0 = done_cnt;
    do_start(9'h010, 4, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("basic_rvalid_%0d", k), bram_r_valid, (k <= 4));
      if (k <= 4) check($sformatf("basic_raddr_%0d", k), bram_r_addr, 9'h010 + AW'(k - 1));
      check($sformatf("basic_mvalid_%0d", k), m_valid, (k >= 3 && k <= 6));
      check($sformatf("basic_mlast_%0d", k), m_last, (k == 6));
      check($sformatf("basic_done_%0d", k), done, (k == 7));
      check($sformatf("basic_busy_%0d", k), busy, (k <= 7));
    end
    check("basic_done_once", done_cnt - d0, 1);
    check("basic_sb_left", exp_q.size(), 0);

    // Zero length
    d0 = done_cnt;
    do_start(9'h055, 0, 1'b1);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      check($sformatf("zero_done_%0d", k), done, (k == 1));
      check($sformatf("zero_busy_%0d", k), busy, (k == 1));
      check($sformatf("zero_rvalid_%0d", k), bram_r_valid, 1'b0);
      check($sformatf("zero_mvalid_%0d", k), m_valid, 1'b0);
    end
    check("zero_done_once", done_cnt - d0, 1);

    run_burst(9'h0A0, 8, 1);
    run_burst(9'h1FE, 4, 0);

    // Start while busy is ignored
    ready_mode = 2;
    d0 = done_cnt;
    do_start(9'h040, 10, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = 9'h100;
    length = 10'd5;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle();
    check("busy_start_done_once", done_cnt - d0, 1);

    // Reset mid-burst after two beats
    ready_mode = 0;
    a0 = accepted;
    do_start(9'h0C0, 6, 1'b1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (accepted >= a0 + 2) break;
    end
    check("rst_mid_two_beats", accepted >= a0 + 2, 1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    exp_addr_q.delete();
    issued = 0;
    accepted = 0;
    d0 = done_cnt;
    @(negedge clk);
    check("rst_mid_mvalid", m_valid, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_done", done, 1'b0);
    run_burst(9'h0E0, 2, 0);
    check("rst_mid_done_total", done_cnt - d0, 1);

    // Random bursts
    for (int it = 0; it < 24; it++) begin
      int n;
      n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(20, 40)) : int'($urandom_range(0, 8));
      run_burst(AW'($urandom_range(0, 511)), n, int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
